// File: rtl/ramb4_s2_byte_packer.sv
// Byte-to-2-bit serialiser feeding port A of a 2048 x 2 block RAM.
// Each accepted byte becomes four consecutive writes at an auto-incrementing, wrapping pointer.
module ramb4_s2_byte_packer #(
    parameter int ADDR_WIDTH = 11,
    parameter int BASE_ADDR  = 0,
    parameter int LAST_ADDR  = 2047,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLKA,
    input  logic                  RSTB,
    input  logic [7:0]            DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    input  logic                  ADDR_LOAD,
    input  logic [ADDR_WIDTH-1:0] ADDR_VAL,
    output logic [ADDR_WIDTH-1:0] ADDRA,
    output logic [1:0]            DIA,
    output logic                  ENA,
    output logic                  WEA,
    output logic                  BUSY,
    output logic                  WRAP,
    output logic [15:0]           BYTE_COUNT
);

    localparam logic [ADDR_WIDTH-1:0] BASE_L = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_L = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE_L  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [1:0]              phase_r, phase_s;
    logic [7:0]              shift_r, shift_s;
    logic [ADDR_WIDTH-1:0]   ptr_r, ptr_s;
    logic [15:0]             count_r, count_s;
    logic                    wrap_r, wrap_s;
    logic                    ready_s;
    logic                    at_last_s;

    // Reverse order is simply the bitwise complement of the phase.
    function automatic logic [1:0] slice_sel(input logic [7:0] b, input logic [1:0] ph, input bit lsb);
        logic [1:0] idx;
        idx = lsb ? ph : ~ph;
        case (idx)
            2'd0:    slice_sel = b[1:0];
            2'd1:    slice_sel = b[3:2];
            2'd2:    slice_sel = b[5:4];
            2'd3:    slice_sel = b[7:6];
            default: slice_sel = 2'b00;
        endcase
    endfunction

    // Next-state, pointer and handshake decode.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        shift_s   = shift_r;
        ptr_s     = ptr_r;
        count_s   = count_r;
        wrap_s    = 1'b0;
        ready_s   = 1'b0;
        at_last_s = (ptr_r == LAST_L);
        case (state_r)
            ST_IDLE: begin
                // A pointer load takes priority over an incoming byte.
                ready_s = ~ADDR_LOAD;
                if (ADDR_LOAD) begin
                    ptr_s = ADDR_VAL;
                end else if (DIN_VALID) begin
                    state_s = ST_SHIFT;
                    phase_s = 2'd0;
                    shift_s = DIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                ptr_s   = at_last_s ? BASE_L : (ptr_r + ONE_L);
                wrap_s  = at_last_s;
                phase_s = phase_r + 2'd1;
                if (phase_r == 2'd3) begin
                    ready_s = 1'b1;
                    count_s = count_r + 16'd1;
                    if (DIN_VALID) begin
                        shift_s = DIN;
                        phase_s = 2'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    ready_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            state_r <= ST_IDLE;
            phase_r <= 2'd0;
            shift_r <= 8'd0;
            ptr_r   <= BASE_L;
            count_r <= 16'd0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            shift_r <= shift_s;
            ptr_r   <= ptr_s;
            count_r <= count_s;
            wrap_r  <= wrap_s;
        end
    end

    assign DIN_READY  = ready_s & ~RSTB;
    assign BUSY       = (state_r == ST_SHIFT);
    assign ENA        = BUSY;
    assign WEA        = BUSY;
    assign ADDRA      = ptr_r;
    assign DIA        = BUSY ? slice_sel(shift_r, phase_r, LSB_FIRST) : 2'b00;
    assign WRAP       = wrap_r;
    assign BYTE_COUNT = count_r;

endmodule

// File: tb/tb_ramb4_s2_byte_packer.sv
// Directed table-driven bench for ramb4_s2_byte_packer; a second instance covers MSB-first order.
module tb_ramb4_s2_byte_packer;

    logic        clk;
    logic        rstb;
    logic [7:0]  din;
    logic        din_valid;
    logic        addr_load;
    logic [10:0] addr_val;

    logic        ready, ena, wea, busy, wrap;
    logic [10:0] addra;
    logic [1:0]  dia;
    logic [15:0] count;

    logic        m_ready, m_ena, m_wea, m_busy, m_wrap;
    logic [10:0] m_addra;
    logic [1:0]  m_dia;
    logic [15:0] m_count;

    int checks = 0;
    int errors = 0;

    ramb4_s2_byte_packer #(.LSB_FIRST(1'b1)) u_dut (
        .CLKA(clk), .RSTB(rstb), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(ready),
        .ADDR_LOAD(addr_load), .ADDR_VAL(addr_val), .ADDRA(addra), .DIA(dia),
        .ENA(ena), .WEA(wea), .BUSY(busy), .WRAP(wrap), .BYTE_COUNT(count)
    );

    ramb4_s2_byte_packer #(.LSB_FIRST(1'b0)) u_msb (
        .CLKA(clk), .RSTB(rstb), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(m_ready),
        .ADDR_LOAD(addr_load), .ADDR_VAL(addr_val), .ADDRA(m_addra), .DIA(m_dia),
        .ENA(m_ena), .WEA(m_wea), .BUSY(m_busy), .WRAP(m_wrap), .BYTE_COUNT(m_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [7:0]  din;
        logic        valid;
        logic        load;
        logic [10:0] aval;
        logic        rdy;
        logic        ena;
        logic [10:0] addr;
        logic [1:0]  dia;
        logic [1:0]  dia_m;
        logic        busy;
        logic        wrap;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [7:0] d, input logic v, input logic ld,
                       input logic [10:0] av, input logic rdy, input logic en, input logic [10:0] ad,
                       input logic [1:0] dl, input logic [1:0] dm, input logic bz, input logic wr,
                       input logic [15:0] cn);
        vec_t t;
        t.rst = rst; t.din = d; t.valid = v; t.load = ld; t.aval = av;
        t.rdy = rdy; t.ena = en; t.addr = ad; t.dia = dl; t.dia_m = dm;
        t.busy = bz; t.wrap = wr; t.cnt = cn;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    logic [7:0] bytes [4];
    logic [1:0] exp_dia;
    int         wait_cnt;

    initial begin
        rstb = 1'b1; din = 8'h00; din_valid = 1'b0; addr_load = 1'b0; addr_val = 11'd0;
        repeat (2) @(negedge clk);

        //  rst  din    v    ld   aval      rdy  en   addr      dia   diam  bsy  wrp  cnt
        // Reset state and single byte E4
        add(1'b1, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 11'd0,    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 8'hE4, 1'b1, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd0,    2'd0, 2'd3, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd1,    2'd1, 2'd2, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2,    2'd2, 2'd1, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b1, 11'd3,    2'd3, 2'd0, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd4,    2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
        // Reset, then back-to-back 1B, FF
        add(1'b1, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b0, 11'd4,    2'd0, 2'd0, 1'b0, 1'b0, 16'd1);
        add(1'b0, 8'h1B, 1'b1, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 8'hFF, 1'b1, 1'b0, 11'd0,    1'b0, 1'b1, 11'd0,    2'd3, 2'd0, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'hFF, 1'b1, 1'b0, 11'd0,    1'b0, 1'b1, 11'd1,    2'd2, 2'd1, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'hFF, 1'b1, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2,    2'd1, 2'd2, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'hFF, 1'b1, 1'b0, 11'd0,    1'b1, 1'b1, 11'd3,    2'd0, 2'd3, 1'b1, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd4,    2'd3, 2'd3, 1'b1, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd5,    2'd3, 2'd3, 1'b1, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd6,    2'd3, 2'd3, 1'b1, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b1, 11'd7,    2'd3, 2'd3, 1'b1, 1'b0, 16'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd8,    2'd0, 2'd0, 1'b0, 1'b0, 16'd2);
        // Load 2044 colliding with a valid byte (load wins), then wrap; load in SHIFT ignored
        add(1'b0, 8'h1B, 1'b1, 1'b1, 11'd2044, 1'b0, 1'b0, 11'd8,    2'd0, 2'd0, 1'b0, 1'b0, 16'd2);
        add(1'b0, 8'hE4, 1'b1, 1'b0, 11'd0,    1'b1, 1'b0, 11'd2044, 2'd0, 2'd0, 1'b0, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2044, 2'd0, 2'd3, 1'b1, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2045, 2'd1, 2'd2, 1'b1, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2046, 2'd2, 2'd1, 1'b1, 1'b0, 16'd2);
        add(1'b0, 8'h1B, 1'b1, 1'b0, 11'd0,    1'b1, 1'b1, 11'd2047, 2'd3, 2'd0, 1'b1, 1'b0, 16'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd0,    2'd3, 2'd0, 1'b1, 1'b1, 16'd3);
        add(1'b0, 8'h00, 1'b0, 1'b1, 11'd100,  1'b0, 1'b1, 11'd1,    2'd2, 2'd1, 1'b1, 1'b0, 16'd3);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd2,    2'd1, 2'd2, 1'b1, 1'b0, 16'd3);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b1, 11'd3,    2'd0, 2'd3, 1'b1, 1'b0, 16'd3);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd4,    2'd0, 2'd0, 1'b0, 1'b0, 16'd4);
        // Load 40, byte AA, reset during phase 2
        add(1'b0, 8'h00, 1'b0, 1'b1, 11'd40,   1'b0, 1'b0, 11'd4,    2'd0, 2'd0, 1'b0, 1'b0, 16'd4);
        add(1'b0, 8'hAA, 1'b1, 1'b0, 11'd0,    1'b1, 1'b0, 11'd40,   2'd0, 2'd0, 1'b0, 1'b0, 16'd4);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd40,   2'd2, 2'd2, 1'b1, 1'b0, 16'd4);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd41,   2'd2, 2'd2, 1'b1, 1'b0, 16'd4);
        add(1'b1, 8'h00, 1'b0, 1'b0, 11'd0,    1'b0, 1'b1, 11'd42,   2'd2, 2'd2, 1'b1, 1'b0, 16'd4);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 11'd0,    1'b1, 1'b0, 11'd0,    2'd0, 2'd0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rstb = vecs[i].rst; din = vecs[i].din; din_valid = vecs[i].valid;
            addr_load = vecs[i].load; addr_val = vecs[i].aval;
            #1;
            chk("DIN_READY",  i, 32'(ready),   32'(vecs[i].rdy));
            chk("ENA",        i, 32'(ena),     32'(vecs[i].ena));
            chk("WEA",        i, 32'(wea),     32'(vecs[i].ena));
            chk("ADDRA",      i, 32'(addra),   32'(vecs[i].addr));
            chk("DIA",        i, 32'(dia),     32'(vecs[i].dia));
            chk("DIA_MSB",    i, 32'(m_dia),   32'(vecs[i].dia_m));
            chk("BUSY",       i, 32'(busy),    32'(vecs[i].busy));
            chk("WRAP",       i, 32'(wrap),    32'(vecs[i].wrap));
            chk("BYTE_COUNT", i, 32'(count),   32'(vecs[i].cnt));
        end

        // Four bytes streamed with valid held: 16 gap-free writes at 0..15
        bytes[0] = 8'h5A; bytes[1] = 8'hC3; bytes[2] = 8'h0F; bytes[3] = 8'h96;
        addr_load = 1'b0; rstb = 1'b0;
        @(negedge clk);
        din = bytes[0]; din_valid = 1'b1;
        #1;
        chk("stream_ready0", 100, 32'(ready), 32'd1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            din       = (j < 12) ? bytes[(j / 4) + 1] : 8'h00;
            din_valid = (j < 12);
            #1;
            exp_dia = 2'((bytes[j / 4] >> (2 * (j % 4))) & 8'h03);
            chk("stream_ena",   200 + j, 32'(ena),   32'd1);
            chk("stream_addr",  200 + j, 32'(addra), 32'(j));
            chk("stream_dia",   200 + j, 32'(dia),   32'(exp_dia));
            chk("stream_ready", 200 + j, 32'(ready), 32'((j % 4) == 3));
        end
        @(negedge clk);
        din_valid = 1'b0;
        wait_cnt = 0;
        while (busy !== 1'b0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        chk("stream_idle_timeout", 300, 32'(busy),  32'd0);
        chk("stream_count",        301, 32'(count), 32'd4);
        chk("stream_addr_end",     302, 32'(addra), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
